// File: rtl/screen_sequencer.sv
// Steps through NUM_SCREENS timed screens with start/pause/skip/force control.
// Define SCREEN_LOOP_EN to wrap from the last screen back to screen 0 instead of stopping.
module screen_sequencer #(
    parameter int NUM_SCREENS = 4,
    parameter int SCR_W       = 2,
    parameter int SEC_W       = 8,
    parameter int CLK_HZ      = 50000000,
    parameter logic [NUM_SCREENS*SEC_W-1:0] SCREEN_SECS = {8'd10, 8'd30, 8'd5, 8'd3}
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             pause,
    input  logic             skip,
    input  logic             force_valid,
    input  logic [SCR_W-1:0] force_screen,
    output logic [SCR_W-1:0] curr_screen,
    output logic [SEC_W-1:0] secs_left,
    output logic             sec_tick,
    output logic             screen_change,
    output logic             end_of_game,
    output logic             busy
);
    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int TAB_N = 1 << SCR_W;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(NUM_SCREENS - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t           state, state_n;
    logic [PRE_W-1:0] prescaler, pre_n;
    logic [SCR_W-1:0] scr_n, ld_idx;
    logic [SEC_W-1:0] secs_n;
    logic             tick_n, chg_n, eog_n;
    logic             do_load, do_adv, force_ok;

    // Duration table padded to a power of two so any index is safe; zero durations become 1.
    logic [SEC_W-1:0] dur_tab [TAB_N];
    for (genvar i = 0; i < TAB_N; i++) begin : g_dur
        if (i < NUM_SCREENS) begin : g_used
            localparam logic [SEC_W-1:0] D = SCREEN_SECS[i*SEC_W +: SEC_W];
            assign dur_tab[i] = (D == '0) ? SEC_W'(1) : D;
        end else begin : g_pad
            assign dur_tab[i] = SEC_W'(1);
        end
    end

    assign force_ok = (32'(force_screen) < NUM_SCREENS);

    always_comb begin
        state_n = state;
        scr_n   = curr_screen;
        secs_n  = secs_left;
        pre_n   = prescaler;
        tick_n  = 1'b0;
        chg_n   = 1'b0;
`ifdef SCREEN_LOOP_EN
        eog_n   = 1'b0;
`else
        eog_n   = end_of_game;
`endif
        do_load = 1'b0;
        do_adv  = 1'b0;
        ld_idx  = '0;

        if (force_valid && force_ok) begin
            do_load = 1'b1;
            ld_idx  = force_screen;
            state_n = RUN;
            eog_n   = 1'b0;
        end else if (start && (state == IDLE || state == DONE)) begin
            do_load = 1'b1;
            state_n = RUN;
            eog_n   = 1'b0;
        end else if (skip && (state == RUN || state == HOLD)) begin
            do_adv = 1'b1;
        end else if (state == RUN || state == HOLD) begin
            if (pause) begin
                state_n = HOLD;
            end else begin
                // Leaving HOLD counts in the same cycle so a pause of N cycles costs exactly N.
                state_n = RUN;
                if (prescaler == PRE_LAST) begin
                    pre_n  = '0;
                    tick_n = 1'b1;
                    if (secs_left == SEC_W'(1)) do_adv = 1'b1;
                    else                        secs_n = secs_left - SEC_W'(1);
                end else begin
                    pre_n = prescaler + PRE_W'(1);
                end
            end
        end

        if (do_adv) begin
            if (curr_screen == SCR_LAST) begin
`ifdef SCREEN_LOOP_EN
                do_load = 1'b1;
                eog_n   = 1'b1;
`else
                state_n = DONE;
                secs_n  = '0;
                eog_n   = 1'b1;
`endif
            end else begin
                do_load = 1'b1;
                ld_idx  = curr_screen + SCR_W'(1);
            end
        end

        if (do_load) begin
            scr_n  = ld_idx;
            secs_n = dur_tab[ld_idx];
            pre_n  = '0;
            chg_n  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            prescaler     <= '0;
            curr_screen   <= '0;
            secs_left     <= '0;
            sec_tick      <= 1'b0;
            screen_change <= 1'b0;
            end_of_game   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            prescaler     <= pre_n;
            curr_screen   <= scr_n;
            secs_left     <= secs_n;
            sec_tick      <= tick_n;
            screen_change <= chg_n;
            end_of_game   <= eog_n;
            busy          <= (state_n == RUN) || (state_n == HOLD);
        end
    end
endmodule
